// File: rtl/fetch_group_gen.sv
// -----------------------------------------------------------------------------
// config_pkg
//   Global configuration record shared by the front-end blocks.
//
// fetch_group_gen
//   Instruction fetch controller placed directly in front of the instruction
//   buffer. It holds the fetch PC and sends one group-aligned request at a time
//   to the I-cache. It registers each response and presents it downstream as
//   one fetch group on a valid/ready interface. A backend redirect replaces the
//   fetch PC. A response that was already in flight when the redirect arrived
//   is dropped and never reaches the fe_* outputs.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   redirect_valid_i/pc  backend redirect / flush request and its target
//   icache_req_*         aligned fetch request (valid/ready handshake)
//   icache_rsp_*         in-order response, one per accepted request
//   fe_valid_o/ready_i   fetch group handshake to the instruction buffer
//   fe_instrs_o          group instructions, slot 0 at fe_pc_o
//   fe_pc_o              group-aligned PC of slot 0
//   fe_slot_valid_o      per-slot valid (slots before the entry PC are masked)
//   fe_pred_npc_o        per-slot sequential next PC
// -----------------------------------------------------------------------------
package config_pkg;

  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned PLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 32'd4, ILEN: 32'd32, PLEN: 32'd32};

endpackage

module fetch_group_gen #(
  parameter config_pkg::cfg_t           Cfg      = config_pkg::EmptyCfg,
  parameter logic [Cfg.PLEN-1:0]        RESET_PC = 'h8000_0000
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        redirect_valid_i,
  input  logic [Cfg.PLEN-1:0]                         redirect_pc_i,
  output logic                                        icache_req_valid_o,
  input  logic                                        icache_req_ready_i,
  output logic [Cfg.PLEN-1:0]                         icache_req_addr_o,
  input  logic                                        icache_rsp_valid_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]     icache_rsp_data_i,
  output logic                                        fe_valid_o,
  input  logic                                        fe_ready_i,
  output logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]     fe_instrs_o,
  output logic [Cfg.PLEN-1:0]                         fe_pc_o,
  output logic [Cfg.INSTR_PER_FETCH-1:0]              fe_slot_valid_o,
  output logic [Cfg.INSTR_PER_FETCH*Cfg.PLEN-1:0]     fe_pred_npc_o
);

  localparam int unsigned FW          = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN        = Cfg.ILEN;
  localparam int unsigned PLEN        = Cfg.PLEN;
  localparam int unsigned IBYTES      = ILEN / 8;
  localparam int unsigned GROUP_BYTES = FW * ILEN / 8;
  localparam int unsigned LOG_IB      = $clog2(IBYTES);

  localparam logic [PLEN-1:0] GB_MASK = PLEN'(GROUP_BYTES - 1);
  localparam logic [PLEN-1:0] GB_STEP = PLEN'(GROUP_BYTES);

  if ((GROUP_BYTES == 0) || ((GROUP_BYTES & (GROUP_BYTES - 1)) != 0)) begin : g_bad_cfg
    $fatal(1, "fetch_group_gen: GROUP_BYTES must be a power of two");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [PLEN-1:0]   fetch_pc_q;
  logic [PLEN-1:0]   aligned_pc;
  logic [PLEN-1:0]   slot_off;
  logic              redirect_act;
  logic              req_fire;
  logic              fe_fire;
  logic              capture;
  logic [FW-1:0]     slot_valid_d;
  logic [FW*PLEN-1:0] pred_npc_d;

  assign aligned_pc = fetch_pc_q & ~GB_MASK;
  // Index of the instruction slot that the fetch PC points into.
  assign slot_off   = (fetch_pc_q & GB_MASK) >> LOG_IB;

  // The post-reset cycle ignores redirects. In every other state a redirect
  // overrides all other activity.
  assign redirect_act = redirect_valid_i && (state_q != S_IDLE);
  assign req_fire     = icache_req_valid_o && icache_req_ready_i;
  assign fe_fire      = fe_valid_o && fe_ready_i;
  assign capture      = (state_q == S_WAIT) && icache_rsp_valid_i && !redirect_act;

  // The request address is zero outside S_REQ. This keeps it quiet while
  // reset is asserted.
  assign icache_req_addr_o = (state_q == S_REQ) ? aligned_pc : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, whatever order the blocks are in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first. Without it, a path
  // through the case that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d            = state_q;
    icache_req_valid_o = 1'b0;
    fe_valid_o         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        icache_req_valid_o = 1'b1;
        if (redirect_act) begin
          // A request accepted in this cycle is already stale. Its response
          // must be drained.
          state_d = req_fire ? S_DRAIN : S_REQ;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_act) begin
          state_d = icache_rsp_valid_i ? S_REQ : S_DRAIN;
        end else if (icache_rsp_valid_i) begin
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        fe_valid_o = !redirect_act;
        if (redirect_act || fe_ready_i) begin
          state_d = S_REQ;
        end
      end

      S_DRAIN: begin
        if (icache_rsp_valid_i) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
    end else if (redirect_act) begin
      fetch_pc_q <= redirect_pc_i;
    end else if (fe_fire) begin
      // Sequential advance. Wraps modulo 2^PLEN by construction.
      fetch_pc_q <= aligned_pc + GB_STEP;
    end
  end

  // Slot mask and sequential next-PC prediction for the group being captured.
  always_comb begin
    slot_valid_d = '0;
    pred_npc_d   = '0;
    for (int unsigned i = 0; i < FW; i++) begin
      slot_valid_d[i]             = (PLEN'(i) >= slot_off);
      pred_npc_d[i*PLEN +: PLEN]  = aligned_pc + PLEN'((i + 1) * IBYTES);
    end
  end

  // NOTE: the group registers are wide data storage, but they are reset
  // anyway. The fe_* outputs must then read zero during reset and stay
  // deterministic until the first group is captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fe_instrs_o     <= '0;
      fe_pc_o         <= '0;
      fe_slot_valid_o <= '0;
      fe_pred_npc_o   <= '0;
    end else if (capture) begin
      fe_instrs_o     <= icache_rsp_data_i;
      fe_pc_o         <= aligned_pc;
      fe_slot_valid_o <= slot_valid_d;
      fe_pred_npc_o   <= pred_npc_d;
    end
  end

`ifndef SYNTHESIS
  // At most one request is outstanding, so a response can only be legal while
  // the controller is waiting for one or draining one.
  rsp_in_window_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    icache_rsp_valid_i |-> (state_q == S_WAIT || state_q == S_DRAIN));
`endif

endmodule

// File: tb/tb_fetch_group_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_group_gen
//   Self-checking bench for fetch_group_gen with the default configuration
//   (FW=4, ILEN=32, PLEN=32, RESET_PC=0x8000_0000). The bench acts as the
//   I-cache and as the instruction buffer. An independent model computes the
//   expected group for each request and queues it. Each accepted group is
//   popped and compared. Inputs change 1ns after the rising edge. Outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_group_gen;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          redirect_valid_i = 1'b0;
  logic [31:0]   redirect_pc_i = '0;
  logic          icache_req_valid_o;
  logic          icache_req_ready_i = 1'b0;
  logic [31:0]   icache_req_addr_o;
  logic          icache_rsp_valid_i = 1'b0;
  logic [127:0]  icache_rsp_data_i = '0;
  logic          fe_valid_o;
  logic          fe_ready_i = 1'b0;
  logic [127:0]  fe_instrs_o;
  logic [31:0]   fe_pc_o;
  logic [3:0]    fe_slot_valid_o;
  logic [127:0]  fe_pred_npc_o;

  always #5 clk = ~clk;

  fetch_group_gen dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .icache_req_valid_o (icache_req_valid_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_req_addr_o  (icache_req_addr_o),
    .icache_rsp_valid_i (icache_rsp_valid_i),
    .icache_rsp_data_i  (icache_rsp_data_i),
    .fe_valid_o         (fe_valid_o),
    .fe_ready_i         (fe_ready_i),
    .fe_instrs_o        (fe_instrs_o),
    .fe_pc_o            (fe_pc_o),
    .fe_slot_valid_o    (fe_slot_valid_o),
    .fe_pred_npc_o      (fe_pred_npc_o)
  );

  typedef struct {
    logic [31:0]  pc;
    logic [3:0]   slot;
    logic [127:0] pred;
    logic [127:0] instrs;
  } grp_t;

  typedef struct {
    logic [31:0] redirect_pc;
    logic [31:0] exp_pc;
    logic [3:0]  exp_slot;
    logic [31:0] exp_npc3;
  } vec_t;

  grp_t        sb[$];
  logic [31:0] inflight[$];
  logic [31:0] m_pc;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distinct data pattern per aligned address and slot.
  function automatic logic [127:0] data_for(input logic [31:0] a);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      d[i*32 +: 32] = {a[31:4], 4'(i)} ^ 32'hC3A5_5A3C;
    end
    return d;
  endfunction

  function automatic grp_t model(input logic [31:0] pc);
    grp_t g;
    int   off;
    g.pc = {pc[31:4], 4'b0000};
    off  = int'(pc[3:2]);
    for (int i = 0; i < 4; i++) begin
      g.slot[i]          = (i >= off);
      g.pred[i*32 +: 32] = g.pc + 32'((i + 1) * 4);
    end
    g.instrs = data_for(g.pc);
    return g;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    redirect_valid_i   = 1'b0;
    icache_req_ready_i = 1'b0;
    icache_rsp_valid_i = 1'b0;
    fe_ready_i         = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Expect a request in the very next cycle. Stall it for 'stall' cycles, then
  // accept it.
  task automatic req_hs(input logic [31:0] exp_addr, input int stall, input bit deliver);
    begin_cycle();
    for (int s = 0; s < stall; s++) begin
      mid();
      check("req_valid_stall", icache_req_valid_o, 1'b1);
      check("req_addr_stall", icache_req_addr_o, exp_addr);
      begin_cycle();
    end
    icache_req_ready_i = 1'b1;
    mid();
    check("req_valid", icache_req_valid_o, 1'b1);
    check("req_addr", icache_req_addr_o, exp_addr);
    inflight.push_back(exp_addr);
    if (deliver) sb.push_back(model(m_pc));
  endtask

  task automatic rsp(input int delay);
    for (int d = 0; d < delay; d++) begin
      begin_cycle();
      mid();
      check("wait_fe_valid", fe_valid_o, 1'b0);
      check("wait_req_valid", icache_req_valid_o, 1'b0);
    end
    begin_cycle();
    if (inflight.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_inflight: got empty queue expected one request");
    end else begin
      icache_rsp_valid_i = 1'b1;
      icache_rsp_data_i  = data_for(inflight.pop_front());
      mid();
      check("rsp_fe_valid", fe_valid_o, 1'b0);
      check("rsp_req_valid", icache_req_valid_o, 1'b0);
    end
  endtask

  // Expect the group in the very next cycle. Hold ready low 'hold' cycles,
  // then accept the group and compare it with the scoreboard.
  task automatic accept(input int hold, output grp_t seen);
    logic [31:0]  pc0;
    logic [3:0]   sl0;
    logic [127:0] pr0, in0;
    begin_cycle();
    fe_ready_i = (hold == 0);
    mid();
    check("fe_valid", fe_valid_o, 1'b1);
    check("out_req_valid", icache_req_valid_o, 1'b0);
    pc0 = fe_pc_o; sl0 = fe_slot_valid_o; pr0 = fe_pred_npc_o; in0 = fe_instrs_o;
    for (int h = 1; h <= hold; h++) begin
      begin_cycle();
      fe_ready_i = (h == hold);
      mid();
      check("hold_fe_valid", fe_valid_o, 1'b1);
      check("hold_req_valid", icache_req_valid_o, 1'b0);
      check("hold_pc", fe_pc_o, pc0);
      check("hold_slot", fe_slot_valid_o, sl0);
      check("hold_pred", fe_pred_npc_o, pr0);
      check("hold_instrs", fe_instrs_o, in0);
    end
    seen.pc = fe_pc_o; seen.slot = fe_slot_valid_o;
    seen.pred = fe_pred_npc_o; seen.instrs = fe_instrs_o;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got group %0h expected no group", fe_pc_o);
    end else begin
      grp_t g;
      g = sb.pop_front();
      check("grp_pc", fe_pc_o, g.pc);
      check("grp_slot", fe_slot_valid_o, g.slot);
      check("grp_pred", fe_pred_npc_o, g.pred);
      check("grp_instrs", fe_instrs_o, g.instrs);
    end
    m_pc = {m_pc[31:4], 4'b0000} + 32'h10;
  endtask

  task automatic redirect_out(input logic [31:0] pc);
    begin_cycle();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    mid();
    check("redirect_kills_valid", fe_valid_o, 1'b0);
    if (sb.size() != 0) void'(sb.pop_front());
    m_pc = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    grp_t seen;

    vecs[0] = '{32'h8000_0108, 32'h8000_0100, 4'b1100, 32'h8000_0110};
    vecs[1] = '{32'h8000_0004, 32'h8000_0000, 4'b1110, 32'h8000_0010};
    vecs[2] = '{32'h1234_567C, 32'h1234_5670, 4'b1000, 32'h1234_5680};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0000_0010};
    vecs[4] = '{32'hFFFF_FFF4, 32'hFFFF_FFF0, 4'b1110, 32'h0000_0000};

    // Reset: every output is zero.
    repeat (3) @(posedge clk);
    mid();
    check("rst_req_valid", icache_req_valid_o, 1'b0);
    check("rst_req_addr", icache_req_addr_o, 32'h0);
    check("rst_fe_valid", fe_valid_o, 1'b0);
    check("rst_fe_pc", fe_pc_o, 32'h0);
    check("rst_fe_slot", fe_slot_valid_o, 4'h0);
    check("rst_fe_pred", fe_pred_npc_o, 128'h0);
    check("rst_fe_instrs", fe_instrs_o, 128'h0);

    // Release: one idle cycle, then the first request at RESET_PC.
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mid();
    check("idle_no_req", icache_req_valid_o, 1'b0);
    m_pc = 32'h8000_0000;
    req_hs(32'h8000_0000, 0, 1'b1);
    rsp(0);
    accept(0, seen);
    check("first_pred3", seen.pred[127:96], 32'h8000_0010);
    req_hs(32'h8000_0010, 0, 1'b1);
    rsp(1);

    // Redirects while a group is presented. Each entry checks the group at the
    // target and the sequential request that follows it.
    for (int v = 0; v < 5; v++) begin
      redirect_out(vecs[v].redirect_pc);
      req_hs(vecs[v].exp_pc, 0, 1'b1);
      rsp(0);
      accept(0, seen);
      check("tbl_pc", seen.pc, vecs[v].exp_pc);
      check("tbl_slot", seen.slot, vecs[v].exp_slot);
      check("tbl_npc3", seen.pred[127:96], vecs[v].exp_npc3);
      req_hs(vecs[v].exp_pc + 32'h10, 0, 1'b1);
      rsp(0);
    end

    // Downstream stalls for 5 cycles.
    accept(5, seen);

    // Redirect in S_WAIT. The stale response arrives 2 cycles later.
    req_hs(m_pc, 0, 1'b0);
    begin_cycle();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0200;
    mid();
    check("wait_redir_fe_valid", fe_valid_o, 1'b0);
    m_pc = 32'h8000_0200;
    begin_cycle();
    mid();
    check("drain_req_valid", icache_req_valid_o, 1'b0);
    check("drain_fe_valid", fe_valid_o, 1'b0);
    rsp(0);
    // The I-cache holds ready low for 3 cycles.
    req_hs(32'h8000_0200, 3, 1'b1);
    rsp(2);
    accept(0, seen);

    // Redirect in the same cycle as the request handshake.
    begin_cycle();
    check("hs_redir_req_valid", icache_req_valid_o, 1'b1);
    icache_req_ready_i = 1'b1;
    redirect_valid_i   = 1'b1;
    redirect_pc_i      = 32'h8000_0300;
    mid();
    check("hs_redir_addr", icache_req_addr_o, 32'h8000_0210);
    inflight.push_back(32'h8000_0210);
    m_pc = 32'h8000_0300;
    begin_cycle();
    mid();
    check("hs_drain_req_valid", icache_req_valid_o, 1'b0);
    rsp(0);
    req_hs(32'h8000_0300, 0, 1'b1);
    rsp(0);
    accept(0, seen);

    // Redirect in S_WAIT in the same cycle as the response.
    req_hs(32'h8000_0310, 0, 1'b0);
    begin_cycle();
    icache_rsp_valid_i = 1'b1;
    icache_rsp_data_i  = data_for(inflight.pop_front());
    redirect_valid_i   = 1'b1;
    redirect_pc_i      = 32'h8000_0404;
    mid();
    check("wait_rsp_redir_fe_valid", fe_valid_o, 1'b0);
    m_pc = 32'h8000_0404;
    req_hs(32'h8000_0400, 0, 1'b1);
    rsp(0);
    accept(0, seen);
    check("redir_404_slot", seen.slot, 4'b1110);

    // Back-to-back redirects in S_REQ without a handshake. The last one wins.
    begin_cycle();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0500;
    mid();
    check("b2b_addr0", icache_req_addr_o, 32'h8000_0410);
    begin_cycle();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0608;
    mid();
    check("b2b_addr1", icache_req_addr_o, 32'h8000_0500);
    m_pc = 32'h8000_0608;
    req_hs(32'h8000_0600, 0, 1'b1);
    rsp(0);
    accept(0, seen);
    check("b2b_slot", seen.slot, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
